// File: rtl/fir_job_sequencer.sv
// Job-level sequencer for the FIR accelerator: clears the engine, streams coefficients,
// launches the paired source/sink transfers and broadcasts a done event once all have finished.
module fir_job_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int TAP_WIDTH  = 7,
    parameter int N_CORES    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [TAP_WIDTH-1:0]  n_taps_i,
    input  logic [LEN_WIDTH-1:0]  n_samples_i,
    input  logic [ADDR_WIDTH-1:0] coeff_addr_i,
    input  logic [ADDR_WIDTH-1:0] in_addr_i,
    input  logic [ADDR_WIDTH-1:0] out_addr_i,
    output logic                  src_req_o,
    output logic [ADDR_WIDTH-1:0] src_addr_o,
    output logic [LEN_WIDTH-1:0]  src_len_o,
    input  logic                  src_ack_i,
    input  logic                  src_done_i,
    output logic                  sink_req_o,
    output logic [ADDR_WIDTH-1:0] sink_addr_o,
    output logic [LEN_WIDTH-1:0]  sink_len_o,
    input  logic                  sink_ack_i,
    input  logic                  sink_done_i,
    output logic                  eng_clear_o,
    output logic                  eng_coef_load_o,
    output logic [TAP_WIDTH-1:0]  eng_ntaps_o,
    input  logic                  out_valid_i,
    input  logic                  out_ready_i,
    output logic [LEN_WIDTH-1:0]  out_cnt_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [N_CORES-1:0]    evt_o
);
    // Request handshake: a request stays high until the cycle its ack is sampled
    // (same-cycle req/ack counts), and drops on the following cycle.
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_COEF_REQ, S_COEF_WAIT, S_DATA_REQ, S_STREAM, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] coeff_addr_q, in_addr_q, out_addr_q;
    logic [LEN_WIDTH-1:0]  n_samples_q;
    logic [LEN_WIDTH-1:0]  out_cnt_d;
    logic                  src_acked_q, src_acked_d, sink_acked_q, sink_acked_d;
    logic                  src_fin_q, src_fin_d, sink_fin_q, sink_fin_d;
    logic                  start_ok, accept, reject, in_data, hs;

    always_comb begin
        start_ok = (n_taps_i != '0) && (n_samples_i != '0);
        accept   = (state_q == S_IDLE) && start_i && start_ok;
        reject   = (state_q == S_IDLE) && start_i && !start_ok;
        in_data  = (state_q == S_DATA_REQ) || (state_q == S_STREAM);
        hs       = in_data && out_valid_i && out_ready_i;

        if (accept)
            out_cnt_d = '0;
        else if (hs && (out_cnt_o != n_samples_q))
            out_cnt_d = out_cnt_o + LEN_WIDTH'(1);
        else
            out_cnt_d = out_cnt_o;

        src_acked_d  = src_acked_q;
        sink_acked_d = sink_acked_q;
        src_fin_d    = src_fin_q;
        sink_fin_d   = sink_fin_q;
        if (accept) begin
            src_acked_d  = 1'b0;
            sink_acked_d = 1'b0;
            src_fin_d    = 1'b0;
            sink_fin_d   = 1'b0;
        end else begin
            if ((state_q == S_DATA_REQ) && src_req_o && src_ack_i)   src_acked_d = 1'b1;
            if ((state_q == S_DATA_REQ) && sink_req_o && sink_ack_i) sink_acked_d = 1'b1;
            // A done only counts once its own request has been accepted.
            if (((state_q == S_DATA_REQ) && src_acked_q) || (state_q == S_STREAM))
                src_fin_d = src_fin_q | src_done_i;
            if (((state_q == S_DATA_REQ) && sink_acked_q) || (state_q == S_STREAM))
                sink_fin_d = sink_fin_q | sink_done_i;
        end

        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_CLEAR;
            S_CLEAR:     state_d = S_COEF_REQ;
            S_COEF_REQ:  if (src_ack_i) state_d = S_COEF_WAIT;
            S_COEF_WAIT: if (src_done_i) state_d = S_DATA_REQ;
            S_DATA_REQ:  if (src_acked_d && sink_acked_d) state_d = S_STREAM;
            S_STREAM:    if (src_fin_d && sink_fin_d && (out_cnt_d == n_samples_q)) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q         <= S_IDLE;
            coeff_addr_q    <= '0;
            in_addr_q       <= '0;
            out_addr_q      <= '0;
            n_samples_q     <= '0;
            src_acked_q     <= 1'b0;
            sink_acked_q    <= 1'b0;
            src_fin_q       <= 1'b0;
            sink_fin_q      <= 1'b0;
            src_req_o       <= 1'b0;
            src_addr_o      <= '0;
            src_len_o       <= '0;
            sink_req_o      <= 1'b0;
            sink_addr_o     <= '0;
            sink_len_o      <= '0;
            eng_clear_o     <= 1'b0;
            eng_coef_load_o <= 1'b0;
            eng_ntaps_o     <= '0;
            out_cnt_o       <= '0;
            busy_o          <= 1'b0;
            err_o           <= 1'b0;
            evt_o           <= '0;
        end else begin
            state_q         <= state_d;
            out_cnt_o       <= out_cnt_d;
            src_acked_q     <= src_acked_d;
            sink_acked_q    <= sink_acked_d;
            src_fin_q       <= src_fin_d;
            sink_fin_q      <= sink_fin_d;
            busy_o          <= (state_d != S_IDLE);
            eng_clear_o     <= (state_d == S_CLEAR);
            eng_coef_load_o <= (state_d == S_COEF_REQ) || (state_d == S_COEF_WAIT);
            err_o           <= reject;
            evt_o           <= {N_CORES{state_d == S_DONE}};
            if (accept) begin
                coeff_addr_q <= coeff_addr_i;
                in_addr_q    <= in_addr_i;
                out_addr_q   <= out_addr_i;
                n_samples_q  <= n_samples_i;
                eng_ntaps_o  <= n_taps_i;
            end
            src_req_o  <= 1'b0;
            sink_req_o <= 1'b0;
            if (state_d == S_COEF_REQ) begin
                src_req_o  <= 1'b1;
                src_addr_o <= coeff_addr_q;
                src_len_o  <= LEN_WIDTH'(eng_ntaps_o);
            end
            if (state_d == S_DATA_REQ) begin
                src_req_o   <= !src_acked_d;
                sink_req_o  <= !sink_acked_d;
                src_addr_o  <= in_addr_q;
                src_len_o   <= n_samples_q;
                sink_addr_o <= out_addr_q;
                sink_len_o  <= n_samples_q;
            end
        end
    end
endmodule

// File: tb/tb_fir_job_sequencer.sv
// Bench for fir_job_sequencer: directed and randomized jobs checked against a cycle-level
// model of the job timeline derived from the handshake and completion rules.
module tb_fir_job_sequencer;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int TW = 7;
    localparam int NC = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni, clear_i, start_i;
    logic [TW-1:0] n_taps_i;
    logic [LW-1:0] n_samples_i;
    logic [AW-1:0] coeff_addr_i, in_addr_i, out_addr_i;
    logic          src_req_o, src_ack_i, src_done_i;
    logic [AW-1:0] src_addr_o, sink_addr_o;
    logic [LW-1:0] src_len_o, sink_len_o, out_cnt_o;
    logic          sink_req_o, sink_ack_i, sink_done_i;
    logic          eng_clear_o, eng_coef_load_o;
    logic [TW-1:0] eng_ntaps_o;
    logic          out_valid_i, out_ready_i, busy_o, err_o;
    logic [NC-1:0] evt_o;

    int checks = 0;
    int failures = 0;
    int last_ntaps = 0;

    fir_job_sequencer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAP_WIDTH(TW), .N_CORES(NC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .n_taps_i(n_taps_i), .n_samples_i(n_samples_i),
        .coeff_addr_i(coeff_addr_i), .in_addr_i(in_addr_i), .out_addr_i(out_addr_i),
        .src_req_o(src_req_o), .src_addr_o(src_addr_o), .src_len_o(src_len_o),
        .src_ack_i(src_ack_i), .src_done_i(src_done_i),
        .sink_req_o(sink_req_o), .sink_addr_o(sink_addr_o), .sink_len_o(sink_len_o),
        .sink_ack_i(sink_ack_i), .sink_done_i(sink_done_i),
        .eng_clear_o(eng_clear_o), .eng_coef_load_o(eng_coef_load_o), .eng_ntaps_o(eng_ntaps_o),
        .out_valid_i(out_valid_i), .out_ready_i(out_ready_i), .out_cnt_o(out_cnt_o),
        .busy_o(busy_o), .err_o(err_o), .evt_o(evt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic idle_inputs();
        start_i = 1'b0; clear_i = 1'b0;
        src_ack_i = 1'b0; src_done_i = 1'b0; sink_ack_i = 1'b0; sink_done_i = 1'b0;
        out_valid_i = 1'b0; out_ready_i = 1'b0;
    endtask

    // One full job. Cycle k counts clocks after the accepting edge (k=1 is the CLEAR cycle,
    // k=2 the coefficient request). The environment is open-loop: acks/dones/handshakes are
    // scheduled from the spec timeline, and the model predicts every output cycle by cycle.
    task automatic run_job(input string name, input int ntaps, input int nsamp,
                           input int cack_dly, input int cdone_dly,
                           input int sack_dly, input int kack_dly,
                           input int sdone_dly, input int kdone_dly,
                           input int n_hs, input bit dense, input bit inject);
        logic [AW-1:0] ca, ia, oa;
        int coef_seen, coef_ack_c, coef_done_c, data_start;
        int src_ack_c, sink_ack_c, src_done_c, sink_done_c;
        int hs_cnt, hs_last_c, evt_c, evt_n, err_n, exp_evt, exp_cnt;
        bit exp_src_req, exp_sink_req, exp_busy, exp_load;
        ca = $urandom; ia = $urandom; oa = $urandom;
        coef_seen = 0; coef_ack_c = -1; coef_done_c = -1; data_start = -1;
        src_ack_c = -1; sink_ack_c = -1; src_done_c = -1; sink_done_c = -1;
        hs_cnt = 0; hs_last_c = -1; evt_c = -1; evt_n = 0; err_n = 0;
        @(negedge clk_i);
        idle_inputs();
        start_i = 1'b1; n_taps_i = TW'(ntaps); n_samples_i = LW'(nsamp);
        coeff_addr_i = ca; in_addr_i = ia; out_addr_i = oa;
        @(negedge clk_i);
        for (int k = 1; k <= 2000; k++) begin
            exp_busy     = (evt_c < 0) || (k <= evt_c);
            exp_load     = (k >= 2) && (data_start < 0);
            exp_src_req  = ((k >= 2) && (coef_ack_c < 0)) || ((data_start > 0) && (src_ack_c < 0));
            exp_sink_req = (data_start > 0) && (sink_ack_c < 0);
            exp_cnt      = (hs_cnt < nsamp) ? hs_cnt : nsamp;
            checks++; if (busy_o !== exp_busy) begin failures++;
                $display("FAIL %s busy k=%0d got=%b exp=%b", name, k, busy_o, exp_busy); end
            checks++; if (eng_clear_o !== (k == 1)) begin failures++;
                $display("FAIL %s eng_clear k=%0d got=%b", name, k, eng_clear_o); end
            checks++; if (eng_coef_load_o !== exp_load) begin failures++;
                $display("FAIL %s coef_load k=%0d got=%b exp=%b", name, k, eng_coef_load_o, exp_load); end
            checks++; if (src_req_o !== exp_src_req) begin failures++;
                $display("FAIL %s src_req k=%0d got=%b exp=%b", name, k, src_req_o, exp_src_req); end
            checks++; if (sink_req_o !== exp_sink_req) begin failures++;
                $display("FAIL %s sink_req k=%0d got=%b exp=%b", name, k, sink_req_o, exp_sink_req); end
            checks++; if (out_cnt_o !== LW'(exp_cnt)) begin failures++;
                $display("FAIL %s out_cnt k=%0d got=%0d exp=%0d", name, k, out_cnt_o, exp_cnt); end
            checks++; if (eng_ntaps_o !== TW'(ntaps)) begin failures++;
                $display("FAIL %s eng_ntaps k=%0d got=%0d exp=%0d", name, k, eng_ntaps_o, ntaps); end
            if (k == 2) begin
                checks++; if (src_addr_o !== ca || src_len_o !== LW'(ntaps)) begin failures++;
                    $display("FAIL %s coef_desc got=%h/%0d exp=%h/%0d", name, src_addr_o, src_len_o, ca, ntaps); end
            end
            if (k == data_start) begin
                checks++; if (src_addr_o !== ia || src_len_o !== LW'(nsamp)) begin failures++;
                    $display("FAIL %s src_desc got=%h/%0d exp=%h/%0d", name, src_addr_o, src_len_o, ia, nsamp); end
                checks++; if (sink_addr_o !== oa || sink_len_o !== LW'(nsamp)) begin failures++;
                    $display("FAIL %s sink_desc got=%h/%0d exp=%h/%0d", name, sink_addr_o, sink_len_o, oa, nsamp); end
            end
            if (err_o !== 1'b0) err_n++;
            if (evt_o !== '0) begin
                evt_n++;
                if (evt_c < 0) evt_c = k;
                checks++; if (evt_o !== '1) begin failures++;
                    $display("FAIL %s evt_value k=%0d got=%b exp=all ones", name, k, evt_o); end
            end
            if ((evt_c >= 0) && (k == evt_c + 1)) break;

            idle_inputs();
            n_taps_i = TW'($urandom); n_samples_i = LW'($urandom);
            coeff_addr_i = $urandom; in_addr_i = $urandom; out_addr_i = $urandom;
            if ((k >= 2) && (coef_ack_c < 0)) begin
                if (coef_seen == cack_dly) begin src_ack_i = 1'b1; coef_ack_c = k; end
                coef_seen++;
            end
            if (inject && (coef_ack_c >= 0) && (k == coef_ack_c + 1) && (data_start < 0)) begin
                start_i = 1'b1; n_samples_i = '0;
            end
            if ((coef_ack_c >= 0) && (coef_done_c < 0) && (k == coef_ack_c + cdone_dly)) begin
                src_done_i = 1'b1; coef_done_c = k; data_start = k + 1;
            end
            if ((data_start > 0) && (k >= data_start)) begin
                if ((src_ack_c < 0) && (k == data_start + sack_dly)) begin src_ack_i = 1'b1; src_ack_c = k; end
                if ((sink_ack_c < 0) && (k == data_start + kack_dly)) begin sink_ack_i = 1'b1; sink_ack_c = k; end
                if ((src_ack_c >= 0) && (src_done_c < 0) && (k == src_ack_c + sdone_dly)) begin
                    src_done_i = 1'b1; src_done_c = k; end
                if ((sink_ack_c >= 0) && (sink_done_c < 0) && (k == sink_ack_c + kdone_dly)) begin
                    sink_done_i = 1'b1; sink_done_c = k; end
                if (hs_cnt < n_hs) begin
                    out_valid_i = dense || ($urandom_range(0, 3) != 0);
                    out_ready_i = dense || ($urandom_range(0, 3) != 0);
                    if (out_valid_i && out_ready_i) begin
                        hs_cnt++;
                        if (hs_cnt == nsamp) hs_last_c = k;
                    end
                end
            end else if (exp_load) begin
                out_valid_i = 1'($urandom_range(0, 1)); out_ready_i = 1'b1;
            end
            @(negedge clk_i);
        end
        idle_inputs();
        last_ntaps = ntaps;
        if ((src_ack_c < 0) || (sink_ack_c < 0) || (src_done_c < 0) || (sink_done_c < 0) || (hs_last_c < 0))
            exp_evt = -1;
        else
            exp_evt = max2(max2(max2(src_ack_c, sink_ack_c) + 1, max2(src_done_c, sink_done_c)), hs_last_c) + 1;
        checks++; if (evt_c !== exp_evt) begin failures++;
            $display("FAIL %s evt_cycle got=%0d exp=%0d", name, evt_c, exp_evt); end
        checks++; if (evt_n !== 1) begin failures++;
            $display("FAIL %s evt_count got=%0d exp=1", name, evt_n); end
        checks++; if (err_n !== 0) begin failures++;
            $display("FAIL %s err_seen got=%0d exp=0", name, err_n); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            start_i = 1'b1; n_taps_i = 7'd9; n_samples_i = 16'd9;
            src_ack_i = 1'b1; out_valid_i = 1'b1; out_ready_i = 1'b1;
        end
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1'b1;
        checks++; if ({src_req_o, sink_req_o, eng_clear_o, eng_coef_load_o, busy_o, err_o} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=0",
                {src_req_o, sink_req_o, eng_clear_o, eng_coef_load_o, busy_o, err_o}); end
        checks++; if ({src_addr_o, sink_addr_o, src_len_o, sink_len_o, out_cnt_o, eng_ntaps_o, evt_o} !== '0) begin
            failures++; $display("FAIL reset_values src_addr=%h sink_addr=%h cnt=%0d ntaps=%0d evt=%b",
                src_addr_o, sink_addr_o, out_cnt_o, eng_ntaps_o, evt_o); end
    endtask

    task automatic test_zero_reject(input string name, input int ntaps, input int nsamp);
        @(negedge clk_i);
        idle_inputs();
        start_i = 1'b1; n_taps_i = TW'(ntaps); n_samples_i = LW'(nsamp);
        coeff_addr_i = $urandom; in_addr_i = $urandom; out_addr_i = $urandom;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++; if (err_o !== (k == 1)) begin failures++;
                $display("FAIL %s err k=%0d got=%b exp=%b", name, k, err_o, (k == 1)); end
            checks++; if ({busy_o, src_req_o, sink_req_o, eng_clear_o} !== 4'b0) begin failures++;
                $display("FAIL %s activity k=%0d got=%b exp=0000", name, k,
                    {busy_o, src_req_o, sink_req_o, eng_clear_o}); end
            checks++; if (eng_ntaps_o !== TW'(last_ntaps)) begin failures++;
                $display("FAIL %s ntaps_held got=%0d exp=%0d", name, eng_ntaps_o, last_ntaps); end
            @(negedge clk_i);
        end
    endtask

    task automatic test_nominal();
        run_job("nominal", 8, 32, 0, 8, 0, 0, 32, 33, 32, 1'b1, 1'b0);
    endtask

    task automatic test_min_latency();
        run_job("min_latency", 1, 1, 0, 1, 0, 0, 1, 1, 1, 1'b1, 1'b0);
    endtask

    task automatic test_ack_order();
        run_job("ack_order", 4, 32, 0, 2, 3, 0, 40, 2, 32, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        run_job("saturation", 8, 32, 1, 3, 0, 1, 50, 50, 40, 1'b1, 1'b0);
    endtask

    task automatic test_start_in_coef_wait();
        run_job("start_in_coef_wait", 5, 6, 2, 4, 1, 1, 3, 4, 6, 1'b0, 1'b1);
    endtask

    task automatic test_clear_abort();
        @(negedge clk_i);
        idle_inputs();
        start_i = 1'b1; n_taps_i = 7'd3; n_samples_i = 16'd10;
        coeff_addr_i = $urandom; in_addr_i = $urandom; out_addr_i = $urandom;
        @(negedge clk_i);                                     // k=1 CLEAR
        idle_inputs();
        @(negedge clk_i);                                     // k=2 COEF_REQ
        src_ack_i = 1'b1;
        @(negedge clk_i);                                     // k=3 COEF_WAIT
        idle_inputs(); src_done_i = 1'b1;
        @(negedge clk_i);                                     // k=4 DATA_REQ
        idle_inputs();
        checks++; if ({src_req_o, sink_req_o} !== 2'b11) begin failures++;
            $display("FAIL clear_abort data_req got=%b exp=11", {src_req_o, sink_req_o}); end
        src_ack_i = 1'b1; sink_ack_i = 1'b1; out_valid_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk_i);                                     // k=5 STREAM
        idle_inputs();
        checks++; if (busy_o !== 1'b1 || out_cnt_o !== 16'd1) begin failures++;
            $display("FAIL clear_abort stream got busy=%b cnt=%0d exp busy=1 cnt=1", busy_o, out_cnt_o); end
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        checks++; if ({src_req_o, sink_req_o, eng_clear_o, eng_coef_load_o, busy_o, err_o, evt_o} !== '0) begin
            failures++; $display("FAIL clear_abort flags got=%b exp=0",
                {src_req_o, sink_req_o, eng_clear_o, eng_coef_load_o, busy_o, err_o, evt_o}); end
        checks++; if ({src_addr_o, sink_addr_o, src_len_o, sink_len_o, out_cnt_o, eng_ntaps_o} !== '0) begin
            failures++; $display("FAIL clear_abort values src_addr=%h sink_addr=%h cnt=%0d ntaps=%0d",
                src_addr_o, sink_addr_o, out_cnt_o, eng_ntaps_o); end
        last_ntaps = 0;
        src_done_i = 1'b1; sink_done_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            idle_inputs();
            checks++; if (evt_o !== '0 || busy_o !== 1'b0) begin failures++;
                $display("FAIL clear_abort quiet k=%0d evt=%b busy=%b exp 0/0", k, evt_o, busy_o); end
        end
        run_job("after_clear", 6, 12, 0, 2, 1, 0, 5, 6, 12, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            int ns;
            ns = $urandom_range(1, 40);
            run_job($sformatf("random_%0d", j), $urandom_range(1, 127), ns,
                    $urandom_range(0, 4), $urandom_range(1, 6),
                    $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(1, 30), $urandom_range(1, 30),
                    ns + $urandom_range(0, 5), 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        n_taps_i = '0; n_samples_i = '0;
        coeff_addr_i = '0; in_addr_i = '0; out_addr_i = '0;
        test_reset();
        test_zero_reject("zero_samples", 5, 0);
        test_zero_reject("zero_taps", 0, 12);
        test_nominal();
        test_zero_reject("zero_after_job", 9, 0);
        test_min_latency();
        test_ack_order();
        test_saturation();
        test_start_in_coef_wait();
        test_clear_abort();
        test_random();
        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
